// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage, instruction memory and the decode stage.
//
// Handshake semantics:
//   imem_req/imem_ack: the fetch side raises imem_req with a stable imem_addr
//   and holds both until the cycle imem_ack=1. imem_ack may arrive in the
//   first cycle of imem_req. The transfer completes on the rising edge where
//   imem_req && imem_ack. Only one request is outstanding at a time.
//   if_valid/id_ready: a transfer to decode happens on the rising edge where
//   if_valid && id_ready. While if_valid && !id_ready, if_instr and if_pc do
//   not change. A redirect in the same cycle flushes the presented instruction.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );

    // Environment side: instruction memory, branch unit and decode
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one word request at a time to instruction
// memory and hands each instruction with its PC to decode through a one-entry
// output register backed by a one-entry pend register. A redirect flushes the
// output and either refetches at once or first waits out the stale request.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus,
    output logic [1:0]          state_o
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // FETCH: request outstanding. HOLD: output and pend both full, no request.
    // KILL: stale request still outstanding after a redirect, data discarded.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic [31:0] pend_instr_q;
    logic [31:0] pend_pc_q;

    logic [31:0] redirect_tgt;
    logic [31:0] req_addr_inc;
    logic        out_free;

    assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
    assign req_addr_inc = req_addr_q + 32'd4;
    assign out_free     = !out_valid_q || bus.id_ready;

    // Request is gated by reset so nothing is issued while rst is held, yet it
    // is already high in the first cycle after rst falls.
    assign bus.imem_req  = !rst && (state_q != ST_HOLD);
    assign bus.imem_addr = req_addr_q;
    assign bus.if_valid  = out_valid_q;
    assign bus.if_instr  = out_instr_q;
    assign bus.if_pc     = out_pc_q;
    assign state_o       = state_q;

    // Fetch FSM with PC, request address, output and pend registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= RESET_PC;
            pend_instr_q <= '0;
            pend_pc_q    <= '0;
        end else if (bus.redirect) begin
            // Redirect wins over every other event; the output is flushed and
            // pend is dropped simply by never draining it.
            out_valid_q <= 1'b0;
            pc_q        <= redirect_tgt;
            case (state_q)
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        req_addr_q <= redirect_tgt;
                    end else begin
                        // Keep the stale address on the bus until it is acked.
                        state_q <= ST_KILL;
                    end
                end
                ST_HOLD: begin
                    req_addr_q <= redirect_tgt;
                    state_q    <= ST_FETCH;
                end
                ST_KILL: begin
                    if (bus.imem_ack) begin
                        req_addr_q <= redirect_tgt;
                        state_q    <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end else begin
            // A consume with no new load empties the output; loads below
            // override this.
            if (out_valid_q && bus.id_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        if (out_free) begin
                            out_valid_q <= 1'b1;
                            out_instr_q <= bus.imem_rdata;
                            out_pc_q    <= req_addr_q;
                            pc_q        <= req_addr_inc;
                            req_addr_q  <= req_addr_inc;
                        end else begin
                            pend_instr_q <= bus.imem_rdata;
                            pend_pc_q    <= req_addr_q;
                            pc_q         <= req_addr_inc;
                            state_q      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.id_ready) begin
                        out_valid_q <= 1'b1;
                        out_instr_q <= pend_instr_q;
                        out_pc_q    <= pend_pc_q;
                        req_addr_q  <= pc_q;
                        state_q     <= ST_FETCH;
                    end
                end
                ST_KILL: begin
                    if (bus.imem_ack) begin
                        req_addr_q <= pc_q;
                        state_q    <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a program-order stream model.
module tb_instruction_fetch;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC     = 32'hFFFF_FFF8;
    localparam int          RAND_CYCLES = 3000;

    logic       clk;
    logic       rst;
    logic       rst2;
    logic       drive_rst;
    logic       drive_rst2;
    logic [1:0] state1;
    logic [1:0] state2;

    instruction_fetch_if bus ();
    instruction_fetch_if bus2 ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state1)
    );

    instruction_fetch #(.RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk     (clk),
        .rst     (rst2),
        .bus     (bus2),
        .state_o (state2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          accepted = 0;
    logic [31:0] exp_q[$];

    int   mem_wait;
    int   mem_cnt;
    int   cur_wait;
    logic mem_rand;
    logic mem_new;

    logic        random_on;
    logic        prev_ok;
    logic        p_valid, p_rdy, p_redir, p_req, p_ack;
    logic [31:0] p_addr, p_pc, p_instr;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[13];

    // Memory content: every address holds a distinct, address-derived word.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC001_D00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Instruction memory with fixed or random wait states; drops ack under reset.
    task automatic mem_drive();
        if (rst || !bus.imem_req) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            mem_new        = 1'b1;
        end else begin
            if (mem_new) begin
                cur_wait = mem_rand ? int'($urandom_range(0, 2)) : mem_wait;
                mem_cnt  = 0;
                mem_new  = 1'b0;
            end
            if (mem_cnt >= cur_wait) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = word_of(bus.imem_addr);
                mem_new        = 1'b1;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 32'hDEAD_BEEF;
                mem_cnt++;
            end
        end
        bus2.imem_ack   = !rst2 && bus2.imem_req;
        bus2.imem_rdata = word_of(bus2.imem_addr);
    endtask

    // Stream model: decode must see program order from the last reset or
    // redirect target, each word matching memory, with no loss or duplication.
    task automatic monitor();
        logic [31:0] exp_pc;
        if (prev_ok) begin
            if (p_valid && !p_rdy && !p_redir) begin
                check("hold_valid", bus.if_valid, 1'b1);
                check("hold_pc", bus.if_pc, p_pc);
                check("hold_instr", bus.if_instr, p_instr);
            end
            if (p_req && !p_ack) begin
                check("req_held", bus.imem_req, 1'b1);
                check("addr_stable", bus.imem_addr, p_addr);
            end
        end
        if (bus.redirect) begin
            exp_q.delete();
            exp_q.push_back({bus.redirect_pc[31:2], 2'b00});
        end else if (bus.if_valid && bus.id_ready) begin
            exp_pc = exp_q.pop_front();
            check("stream_pc", bus.if_pc, exp_pc);
            check("stream_instr", bus.if_instr, word_of(exp_pc));
            exp_q.push_back(exp_pc + 32'd4);
            accepted++;
        end
        p_valid = bus.if_valid;
        p_rdy   = bus.id_ready;
        p_redir = bus.redirect;
        p_req   = bus.imem_req;
        p_ack   = bus.imem_ack;
        p_addr  = bus.imem_addr;
        p_pc    = bus.if_pc;
        p_instr = bus.if_instr;
        prev_ok = 1'b1;
    endtask

    // One clock cycle: inputs applied at the falling edge, outputs sampled
    // shortly after, all well before the next rising edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        rst             = drive_rst;
        rst2            = drive_rst2;
        bus.id_ready    = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        #1;
        mem_drive();
        #1;
        if (random_on) monitor();
    endtask

    task automatic do_reset();
        drive_rst = 1'b1;
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        drive_rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic        r_rdy;
        logic        r_redir;
        logic [31:0] r_tgt;
        int          lat;

        rst              = 1'b1;
        rst2             = 1'b1;
        drive_rst        = 1'b1;
        drive_rst2       = 1'b1;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = '0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.id_ready     = 1'b1;
        bus2.imem_ack    = 1'b0;
        bus2.imem_rdata  = '0;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = '0;
        bus2.id_ready    = 1'b1;
        mem_wait         = 0;
        mem_rand         = 1'b0;
        mem_new          = 1'b1;
        mem_cnt          = 0;
        cur_wait         = 0;
        random_on        = 1'b0;
        prev_ok          = 1'b0;

        // Vector table: zero-wait memory; stall for 3 cycles; redirect to
        // 0x203 coinciding with an ack.
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h008};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h00C};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h00C};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h00C};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h010};
        vecs[9]  = '{1'b1, 1'b1, 32'h203, 1'b1, 32'h018, 1'b1, 32'h014};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
        vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
        vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204};

        // Reset values
        do_reset();
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_valid", bus.if_valid, 1'b0);
        check("rst_instr", bus.if_instr, NOP);
        check("rst_pc", bus.if_pc, 32'h0);
        check("rst_wrap_pc", bus2.if_pc, WRAP_PC);
        check("rst_wrap_state", state2, 2'd0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            check($sformatf("t%0d_req", i), bus.imem_req, vecs[i].exp_req);
            if (vecs[i].exp_req)
                check($sformatf("t%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
            check($sformatf("t%0d_valid", i), bus.if_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("t%0d_pc", i), bus.if_pc, vecs[i].exp_pc);
                check($sformatf("t%0d_instr", i), bus.if_instr, word_of(vecs[i].exp_pc));
            end
        end

        // Two wait states, redirect to 0x100 in the first wait cycle
        mem_wait = 2;
        do_reset();
        cycle(1'b1, 1'b1, 32'h100);
        check("a_addr0", bus.imem_addr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("a_state_kill", state1, 2'd2);
        check("a_addr1", bus.imem_addr, 32'h0);
        check("a_valid1", bus.if_valid, 1'b0);
        cycle(1'b1, 1'b0, 32'h0);
        check("a_addr2", bus.imem_addr, 32'h0);
        check("a_ack2", bus.imem_ack, 1'b1);
        cycle(1'b1, 1'b0, 32'h0);
        check("a_req3", bus.imem_req, 1'b1);
        check("a_addr3", bus.imem_addr, 32'h100);
        check("a_valid3", bus.if_valid, 1'b0);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 32'h0);
            if (bus.if_valid) begin
                lat = k;
                break;
            end
        end
        check("a_latency", lat, 3);
        check("a_first_pc", bus.if_pc, 32'h100);
        check("a_first_instr", bus.if_instr, word_of(32'h100));

        // PC wrap at the top of the address space
        mem_wait   = 0;
        drive_rst2 = 1'b1;
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        drive_rst2 = 1'b0;
        cycle(1'b1, 1'b0, 32'h0);
        check("b_req0", bus2.imem_req, 1'b1);
        check("b_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'h0);
        check("b_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
        check("b_pc1", bus2.if_pc, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'h0);
        check("b_addr2", bus2.imem_addr, 32'h0000_0000);
        check("b_pc2", bus2.if_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0);
        check("b_pc3", bus2.if_pc, 32'h0000_0000);
        check("b_instr3", bus2.if_instr, word_of(32'h0));
        drive_rst2 = 1'b1;

        // Reset asserted while in HOLD
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("c_hold_req", bus.imem_req, 1'b0);
        check("c_hold_valid", bus.if_valid, 1'b1);
        check("c_state_hold", state1, 2'd1);
        drive_rst = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("c_rst_valid", bus.if_valid, 1'b0);
        check("c_rst_req", bus.imem_req, 1'b0);
        check("c_rst_instr", bus.if_instr, NOP);
        drive_rst = 1'b0;
        cycle(1'b1, 1'b0, 32'h0);
        check("c_restart_req", bus.imem_req, 1'b1);
        check("c_restart_addr", bus.imem_addr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("c_restart_pc", bus.if_pc, 32'h0);

        // Randomized run against the stream model
        mem_rand = 1'b1;
        do_reset();
        exp_q.delete();
        exp_q.push_back(32'h0);
        prev_ok   = 1'b0;
        random_on = 1'b1;
        for (int i = 0; i < RAND_CYCLES; i++) begin
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_redir = ($urandom_range(0, 39) == 0);
            r_tgt   = $urandom;
            if ($urandom_range(0, 3) == 0) r_tgt = {28'hFFFF_FFF, r_tgt[3:0]};
            cycle(r_rdy, r_redir, r_tgt);
        end
        random_on = 1'b0;
        check("rand_progress", (accepted > 300), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the CPU. Owns the program counter, issues word requests to instruction memory over a req/ack handshake and presents each fetched instruction with its PC to the decode stage through a one-entry output register. The decode stage, including the immediate generator, consumes that output. The block accepts a redirect from the branch/jump unit and discards any fetch made stale by it.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  imem_rdata valid for the current request; may coincide with the first cycle of imem_req.
- imem_rdata  in  32  fetched instruction word.
- redirect  in  1  flush and refetch from redirect_pc; single-cycle pulse.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  instruction to decode.
- if_pc  out  32  address of if_instr.
- id_ready  in  1  decode accepts the output when if_valid && id_ready.

## Operation
- Registers:
  - pc: next fetch address.
  - req_addr: drives imem_addr.
  - out register: if_valid, if_instr, if_pc.
  - pend register: instr/pc, one entry.
  - state.
- States:
  - FETCH: imem_req=1, imem_addr=req_addr.
    - On imem_ack with output free (!if_valid or id_ready this cycle): load out with {imem_rdata, req_addr}, set if_valid=1, set pc and req_addr to req_addr+4, stay in FETCH.
    - On imem_ack with output full and not consumed: load pend, set pc=req_addr+4, go to HOLD.
    - With no ack: stay in FETCH.
  - HOLD: imem_req=0.
    - On id_ready: move pend into out (if_valid stays 1), set req_addr=pc, go to FETCH.
  - KILL: imem_req=1 with the stale req_addr unchanged, so the address is never withdrawn mid-transaction.
    - On imem_ack: discard the data, set req_addr=pc, go to FETCH.
- Consume: if_valid && id_ready with no new load clears if_valid next cycle.
- Redirect has priority over every other event in every state:
  - On the next cycle, if_valid=0 and pend is discarded.
  - pc = {redirect_pc[31:2],2'b00}.
  - FETCH without ack: go to KILL.
  - FETCH with ack in the same cycle: discard the data, set req_addr=pc, stay in FETCH.
  - HOLD: set req_addr=pc, go to FETCH.
  - KILL: update pc only, stay in KILL. With ack in the same cycle, go to FETCH at the new pc.
- Arithmetic: PC increment is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- At most one memory request is outstanding. imem_ack received outside FETCH/KILL is ignored.

## Timing
- While rst=1:
  - imem_req=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC.
  - pc=req_addr=RESET_PC, state=FETCH, pend cleared.
  - imem_ack is ignored.
- Reset asserted mid-transaction abandons the request. The memory must drop any pending ack on rst.
- First cycle after rst falls: imem_req=1, imem_addr=RESET_PC.
- Latency: with zero-wait memory (ack in the same cycle as req), if_valid rises the cycle after the request.
- Throughput: 1 instruction/cycle while id_ready=1. With N wait cycles, output follows ack by 1 cycle.
- Redirect to first fetch of the target:
  - 0 extra cycles: imem_addr=target in the cycle after redirect when no request was outstanding.
  - Otherwise, the cycle after the killed request's ack.
- if_valid, if_instr and if_pc change only on clock edges and hold stable while if_valid && !id_ready.

## Test plan
- Reset, zero-wait memory returning addr-derived data, id_ready=1 → imem_addr 0x0,0x4,0x8 on consecutive cycles; if_pc 0x0,0x4,0x8 one cycle later; if_valid=1 continuously.
- id_ready=0 for 3 cycles after first output → one extra word captured in pend, imem_req=0 in HOLD; on id_ready=1 outputs continue 0x4,0x8 with no instruction lost or duplicated.
- 2-wait-state memory, redirect to 0x100 in the 1st wait cycle:
  - imem_addr stays at the old address until ack, and that data never appears on the output.
  - Next request is 0x100, and the first valid if_pc is 0x100.
- Redirect to 0x203 in the same cycle as ack → ack data dropped; next fetch address 0x200; if_valid=0 for exactly one cycle with zero-wait memory.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted during HOLD with if_valid=1 → next cycle: if_valid=0, imem_req=0, if_instr=0x0000_0013; after release, fetch restarts at RESET_PC.
